// File: rtl/me_control_param.sv
// rtl/me_control_param.sv - two-stage coarse/integer motion-estimation sequencer
// Clamped vector mapping, bypass mode, 4-phase sub-handshakes and a per-stage watchdog.
module me_control_param #(
  parameter int MV_W    = 6,
  parameter int CMV_W   = 5,
  parameter int DIFF_W  = 2,
  parameter int SAD_W   = 16,
  parameter int C_BIAS  = 13,
  parameter int POS_MIN = 0,
  parameter int POS_MAX = 46,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                bypass,
  input  logic [2*MV_W-1:0]   ext_pos,
  output logic                ack,
  output logic                err,
  output logic                busy,
  output logic [2*MV_W-1:0]   min_mvec,
  output logic [SAD_W-1:0]    min_sad,
  output logic                req_d,
  input  logic [2*CMV_W-1:0]  min_mvec_d,
  input  logic                ack_d,
  output logic                req_i,
  output logic [2*MV_W-1:0]   init_pos_i,
  input  logic [SAD_W-1:0]    min_sad_i,
  input  logic [2*DIFF_W-1:0] min_diff_i,
  input  logic                ack_i
);

  localparam int EW   = MV_W + 2;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic signed [EW-1:0] P_MIN   = EW'(POS_MIN);
  localparam logic signed [EW-1:0] P_MAX   = EW'(POS_MAX);
  localparam logic signed [EW-1:0] C_B     = EW'(C_BIAS);
  localparam logic [WD_W-1:0]      WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_D_REQ, S_D_REL, S_CALC_INIT, S_I_REQ, S_I_REL, S_CALC_MV, S_DONE, S_WAIT_FALL
  } state_t;

  state_t              state_q, state_d;
  logic                bypass_q, bypass_d;
  logic [2*MV_W-1:0]   ext_q, ext_d;
  logic [2*CMV_W-1:0]  cmv_q, cmv_d;
  logic [2*MV_W-1:0]   init_q, init_d;
  logic [SAD_W-1:0]    sad_q, sad_d;
  logic [2*DIFF_W-1:0] diff_q, diff_d;
  logic [2*MV_W-1:0]   fin_q, fin_d;
  logic                res_ack_q, res_ack_d;
  logic                res_err_q, res_err_d;
  logic [2*MV_W-1:0]   mvec_q, mvec_d;
  logic [SAD_W-1:0]    msad_q, msad_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                waiting, coarse_stage, timeout;

  function automatic logic [MV_W-1:0] clamp(input logic signed [EW-1:0] x);
    logic [MV_W-1:0] r;
    if (x < P_MIN)      r = P_MIN[MV_W-1:0];
    else if (x > P_MAX) r = P_MAX[MV_W-1:0];
    else                r = x[MV_W-1:0];
    return r;
  endfunction

  function automatic logic signed [EW-1:0] from_coarse(input logic [CMV_W-1:0] c);
    return $signed({{(EW-CMV_W-1){1'b0}}, c, 1'b0}) - C_B;
  endfunction

  function automatic logic signed [EW-1:0] zext_pos(input logic [MV_W-1:0] p);
    return $signed({2'b00, p});
  endfunction

  function automatic logic signed [EW-1:0] sext_diff(input logic [DIFF_W-1:0] d);
    return $signed({{(EW-DIFF_W){d[DIFF_W-1]}}, d});
  endfunction

  assign waiting      = (state_q == S_D_REQ) || (state_q == S_D_REL) ||
                        (state_q == S_I_REQ) || (state_q == S_I_REL);
  assign coarse_stage = (state_q == S_D_REQ) || (state_q == S_D_REL);
  assign timeout      = (TIMEOUT != 0) && waiting && (wd_q == WD_LAST);

  always_comb begin
    state_d   = state_q;
    bypass_d  = bypass_q;
    ext_d     = ext_q;
    cmv_d     = cmv_q;
    init_d    = init_q;
    sad_d     = sad_q;
    diff_d    = diff_q;
    fin_d     = fin_q;
    res_ack_d = res_ack_q;
    res_err_d = res_err_q;
    mvec_d    = mvec_q;
    msad_d    = msad_q;
    wd_d      = '0;
    case (state_q)
      S_IDLE: if (req) begin
        bypass_d = bypass;
        ext_d    = ext_pos;
        state_d  = bypass ? S_CALC_INIT : S_D_REQ;
      end
      S_D_REQ: if (ack_d) begin
        cmv_d   = min_mvec_d;
        state_d = S_D_REL;
      end
      S_D_REL: if (!ack_d) state_d = S_CALC_INIT;
      S_CALC_INIT: begin
        if (bypass_q)
          init_d = {clamp(zext_pos(ext_q[2*MV_W-1:MV_W])), clamp(zext_pos(ext_q[MV_W-1:0]))};
        else
          init_d = {clamp(from_coarse(cmv_q[2*CMV_W-1:CMV_W])), clamp(from_coarse(cmv_q[CMV_W-1:0]))};
        state_d = S_I_REQ;
      end
      S_I_REQ: if (ack_i) begin
        sad_d   = min_sad_i;
        diff_d  = min_diff_i;
        state_d = S_I_REL;
      end
      S_I_REL: if (!ack_i) state_d = S_CALC_MV;
      S_CALC_MV: begin
        fin_d = {clamp(zext_pos(init_q[2*MV_W-1:MV_W]) + sext_diff(diff_q[2*DIFF_W-1:DIFF_W])),
                 clamp(zext_pos(init_q[MV_W-1:0]) + sext_diff(diff_q[DIFF_W-1:0]))};
        state_d = S_DONE;
      end
      S_DONE: begin
        mvec_d    = fin_q;
        msad_d    = sad_q;
        res_ack_d = 1'b1;
        state_d   = S_WAIT_FALL;
      end
      S_WAIT_FALL: if (!req) begin
        res_ack_d = 1'b0;
        res_err_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A stalled peer aborts the block; a coarse-stage abort has no start position yet.
    if (timeout) begin
      state_d   = S_DONE;
      res_err_d = 1'b1;
      sad_d     = '1;
      fin_d     = coarse_stage ? '0 : init_q;
    end
    if (waiting && (state_d == state_q)) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bypass_q  <= 1'b0;
      ext_q     <= '0;
      cmv_q     <= '0;
      init_q    <= '0;
      sad_q     <= '0;
      diff_q    <= '0;
      fin_q     <= '0;
      res_ack_q <= 1'b0;
      res_err_q <= 1'b0;
      mvec_q    <= '0;
      msad_q    <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      bypass_q  <= bypass_d;
      ext_q     <= ext_d;
      cmv_q     <= cmv_d;
      init_q    <= init_d;
      sad_q     <= sad_d;
      diff_q    <= diff_d;
      fin_q     <= fin_d;
      res_ack_q <= res_ack_d;
      res_err_q <= res_err_d;
      mvec_q    <= mvec_d;
      msad_q    <= msad_d;
      wd_q      <= wd_d;
    end
  end

  assign req_d      = (state_q == S_D_REQ);
  assign req_i      = (state_q == S_I_REQ);
  assign busy       = (state_q != S_IDLE);
  assign ack        = res_ack_q;
  assign err        = res_err_q;
  assign min_mvec   = mvec_q;
  assign min_sad    = msad_q;
  assign init_pos_i = init_q;

endmodule
